seq_multiplier_nxn: RTL and testbench
=====================================

// Module: seq_multiplier_nxn
// PURPOSE
//   Parametrised sequential WIDTHxWIDTH multiplier built around one CHUNKxCHUNK partial-product multiplier.
//   Iterates over every (a-chunk, b-chunk) pair, shift-adding each partial product into a 2*WIDTH accumulator.
//   Generalises the fixed 8x8/4-bit datapath+controller pair into one block. Adds a start/busy/done handshake,
//   a held result, and optional signed operands.
//   Sits between operand sources and the status display; state_out feeds the 7-segment decoder.
// PARAMETERS
//   WIDTH  8  operand width; must be an integer multiple of CHUNK, >= CHUNK
//   CHUNK  4  partial-product multiplier width; NCH = WIDTH/CHUNK chunks per operand
// PORTS
//   clk        in   1        single clock, rising edge
//   reset_a    in   1        asynchronous, active-low reset
//   start      in   1        request; sampled only when busy=0
//   dataa      in   WIDTH    multiplicand, captured on accepted start
//   datab      in   WIDTH    multiplier, captured on accepted start
//   busy       out  1        1 while a multiplication is in progress
//   done       out  1        1 while product holds a valid result
//   product    out  2*WIDTH  result register
//   state_out  out  2        encoded FSM state: 0 IDLE, 1 CALC, 2 FIX, 3 DONE
// BEHAVIOUR
//   - Reset (reset_a=0, any time, including mid-operation): state IDLE, busy=0, done=0, product=0,
//     i=j=0, operands=0. There is no partial completion after release.
//   - IDLE/DONE with start=1 at edge T0: latch dataa/datab, clear accumulator, i=j=0, done=0, busy=1 -> CALC.
//   - CALC, each edge: acc += (a[i*CHUNK+:CHUNK] * b[j*CHUNK+:CHUNK]) << (CHUNK*(i+j)).
//     - j increments. On j wrap (NCH-1 -> 0), i increments.
//     - Arithmetic is unsigned, 2*WIDTH bits, no overflow possible.
//   - The last pair (i=j=NCH-1) is accumulated at edge T(NCH^2). Next state: DONE (unsigned) or FIX (signed).
//   - DONE: busy=0, done=1, product stable until the next accepted start or reset.
//   - Latency: NCH^2 cycles from start edge to done=1 (default 4); +1 with MULT_SIGNED_EN.
//   - start while busy=1 is ignored; operands are not re-captured.
//   - start held high in DONE restarts immediately; done drops at that edge.
//   - dataa/datab changes after capture have no effect.
// CONFIGURATION
//   MULT_SIGNED_EN defined:
//     - Operands are two's complement.
//     - Capture stores |dataa|, |datab| and neg = sign_a ^ sign_b.
//     - CALC runs unchanged.
//     - FIX state (1 cycle): product = neg ? -acc : acc; then DONE.
//     - Most-negative operand magnitude (e.g. 0x80) is held in WIDTH bits as unsigned 2^(WIDTH-1); result is exact.
//   MULT_SIGNED_EN undefined:
//     - Unsigned only; FIX is never entered; encoding 2 is unused.
// STRUCTURE
//   mult_pkg:
//     - state encodings (IDLE/CALC/FIX/DONE)
//     - NCH and index-width localparams, derived via $clog2(NCH) (min 1)
//   Sub-module mult_chunk: combinational CHUNKxCHUNK -> 2*CHUNK unsigned multiplier, one instance.
//   Top: FSM, i/j counters, operand registers, shift-add accumulator.
// TESTING
//   1. Default params, 0xFF x 0xFF: done rises 4 cycles after start edge, product=0xFE01, state_out 1->3.
//   2. 0x00 x 0x5A, then 0x01 x 0xB7 back-to-back (start held in DONE): products 0x0000, then 0x00B7.
//   3. start pulsed during CALC with new operands: ignored; original result delivered on time.
//   4. Reset mid-op: reset_a low on 2nd CALC cycle -> busy=0, done=0, product=0, state_out=0 immediately.
//      A following start completes correctly.
//   5. WIDTH=16, CHUNK=4, 0xABCD x 0x1234: done after 16 cycles, product=0x0C374FA4.
//   6. MULT_SIGNED_EN, default params: 0xFD x 0x05 -> 0xFFF1 after 5 cycles.
//      0x80 x 0x80 -> 0x4000.
//   Scoreboard: random operands vs. reference multiply, all parameter sets, both macro settings.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential NxN multiplier: FSM state encoding,
// default operand/chunk widths and the counter index-width helper.
package mult_pkg;

    // Encoding is visible on state_out and decoded by the status display.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CHUNK = 4;

    // Chunk index counters need at least one bit even when NCH == 1.
    function automatic int idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/mult_chunk.sv
// Combinational CHUNKxCHUNK unsigned partial-product multiplier.
// Ports: a_i, b_i (CHUNK-bit operands), p_o (2*CHUNK-bit product).
module mult_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]   a_i,
    input  logic [CHUNK-1:0]   b_i,
    output logic [2*CHUNK-1:0] p_o
);

    assign p_o = {{CHUNK{1'b0}}, a_i} * {{CHUNK{1'b0}}, b_i};

endmodule

// File: rtl/seq_multiplier_nxn.sv
// Sequential WIDTHxWIDTH multiplier: one CHUNKxCHUNK multiplier visits every
// (a-chunk, b-chunk) pair and shift-adds it into a 2*WIDTH accumulator.
// Ports: clk, reset_a (async active-low), start, dataa, datab,
//        busy, done, product (2*WIDTH), state_out (0 IDLE 1 CALC 2 FIX 3 DONE).
// Macro MULT_SIGNED_EN: two's complement operands, adds one FIX cycle.
module seq_multiplier_nxn
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         state_out
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = idx_w(NCH);
    localparam int PW  = 2 * WIDTH;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    i_q, j_q;
    logic [PW-1:0]    acc_q, acc_d;
    logic             busy_q, done_q;
`ifdef MULT_SIGNED_EN
    logic             neg_q;
`endif

    logic [CHUNK-1:0]   a_ch, b_ch;
    logic [2*CHUNK-1:0] pp;
    logic [31:0]        shamt;
    logic               last_i, last_j;

    assign a_ch = a_q[i_q*CHUNK +: CHUNK];
    assign b_ch = b_q[j_q*CHUNK +: CHUNK];

    mult_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i (a_ch),
        .b_i (b_ch),
        .p_o (pp)
    );

    // Partial product weight is CHUNK bits per combined chunk index.
    assign shamt  = CHUNK * (32'(i_q) + 32'(j_q));
    assign acc_d  = acc_q + (PW'(pp) << shamt);
    assign last_i = (i_q == IW'(NCH - 1));
    assign last_j = (j_q == IW'(NCH - 1));

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
`ifdef MULT_SIGNED_EN
                        // Magnitudes fit in WIDTH bits when read unsigned,
                        // including the most-negative value.
                        a_q   <= dataa[WIDTH-1] ? -dataa : dataa;
                        b_q   <= datab[WIDTH-1] ? -datab : datab;
                        neg_q <= dataa[WIDTH-1] ^ datab[WIDTH-1];
`else
                        a_q   <= dataa;
                        b_q   <= datab;
`endif
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    if (last_j) begin
                        j_q <= '0;
                        i_q <= last_i ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                    if (last_i && last_j) begin
`ifdef MULT_SIGNED_EN
                        state_q <= ST_FIX;
`else
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end
                end
`ifdef MULT_SIGNED_EN
                ST_FIX: begin
                    acc_q   <= neg_q ? -acc_q : acc_q;
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = acc_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_seq_multiplier_nxn.sv
// Self-checking bench for seq_multiplier_nxn: 8x8/4 and 16x16/4 instances,
// directed cases plus random operands against an arithmetic reference.
module tb_seq_multiplier_nxn;

`ifdef MULT_SIGNED_EN
    localparam int LAT8  = 5;
    localparam int LAT16 = 17;
`else
    localparam int LAT8  = 4;
    localparam int LAT16 = 16;
`endif
    localparam int TMO = 200;

    logic        clk;
    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, busy16, done16;
    logic [15:0] p8;
    logic [31:0] p16;
    logic [1:0]  st8, st16;

    int passed;
    int total;

    seq_multiplier_nxn #(.WIDTH(8), .CHUNK(4)) u_dut8 (
        .clk       (clk),
        .reset_a   (rst_n),
        .start     (start8),
        .dataa     (a8),
        .datab     (b8),
        .busy      (busy8),
        .done      (done8),
        .product   (p8),
        .state_out (st8)
    );

    seq_multiplier_nxn #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk       (clk),
        .reset_a   (rst_n),
        .start     (start16),
        .dataa     (a16),
        .datab     (b16),
        .busy      (busy16),
        .done      (done16),
        .product   (p16),
        .state_out (st16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: integer multiply of the operand values, kept to 2*w bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input int w);
        longint va, vb, r, m;
        va = longint'(a);
        vb = longint'(b);
`ifdef MULT_SIGNED_EN
        if (a[w-1]) va = va - (longint'(1) << w);
        if (b[w-1]) vb = vb - (longint'(1) << w);
`endif
        r = va * vb;
        m = (longint'(1) << (2 * w)) - 1;
        return 32'(r & m);
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat,
                        output logic [1:0] st0);
        @(negedge clk);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        st0 = st8;
        a8 = ~a;
        b8 = ~b;
        lat = 0;
        while (!done8 && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        p = p8;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat);
        @(negedge clk);
        start16 = 1'b1;
        a16 = a;
        b16 = b;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16 = ~a;
        b16 = ~b;
        lat = 0;
        while (!done16 && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        p = p16;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total += 6;
        if (busy8 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy8);
        else passed++;
        if (done8 !== 1'b0) $display("FAIL reset_done got %b want 0", done8);
        else passed++;
        if (p8 !== 16'h0) $display("FAIL reset_prod got %h want 0", p8);
        else passed++;
        if (st8 !== 2'd0) $display("FAIL reset_state got %0d want 0", st8);
        else passed++;
        if (p16 !== 32'h0) $display("FAIL reset_prod16 got %h want 0", p16);
        else passed++;
        if (st16 !== 2'd0) $display("FAIL reset_state16 got %0d want 0", st16);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ff();
        logic [15:0] p, e;
        logic [1:0]  s0;
        int          lat;
        run8(8'hFF, 8'hFF, p, lat, s0);
        e = 16'(ref_mul(16'hFF, 16'hFF, 8));
        total += 5;
        if (s0 !== 2'd1) $display("FAIL ff_state_calc got %0d want 1", s0);
        else passed++;
        if (lat !== LAT8) $display("FAIL ff_latency got %0d want %0d", lat, LAT8);
        else passed++;
        if (p !== e) $display("FAIL ff_product got %h want %h", p, e);
        else passed++;
        if (st8 !== 2'd3) $display("FAIL ff_state_done got %0d want 3", st8);
        else passed++;
        if (busy8 !== 1'b0) $display("FAIL ff_busy got %b want 0", busy8);
        else passed++;
        // Result must hold while idle.
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (p8 !== e || done8 !== 1'b1)
            $display("FAIL ff_hold got %h/%b want %h/1", p8, done8, e);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        int          lat;
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'h00;
        b8 = 8'h5A;
        @(posedge clk);
        #1;
        a8 = 8'h01;
        b8 = 8'hB7;
        lat = 0;
        while (!done8 && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = 16'(ref_mul(16'h00, 16'h5A, 8));
        total += 2;
        if (lat !== LAT8) $display("FAIL b2b_lat1 got %0d want %0d", lat, LAT8);
        else passed++;
        if (p8 !== e) $display("FAIL b2b_prod1 got %h want %h", p8, e);
        else passed++;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        total++;
        if (done8 !== 1'b0 || busy8 !== 1'b1 || st8 !== 2'd1)
            $display("FAIL b2b_restart got d%b b%b s%0d want d0 b1 s1",
                     done8, busy8, st8);
        else passed++;
        lat = 0;
        while (!done8 && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = 16'(ref_mul(16'h01, 16'hB7, 8));
        total += 2;
        if (lat !== LAT8) $display("FAIL b2b_lat2 got %0d want %0d", lat, LAT8);
        else passed++;
        if (p8 !== e) $display("FAIL b2b_prod2 got %h want %h", p8, e);
        else passed++;
    endtask

    task automatic test_ignore_start();
        logic [7:0]  a, b;
        logic [15:0] e;
        int          lat;
        a = 8'hC3;
        b = 8'h6D;
        @(negedge clk);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'h11;
        b8 = 8'h22;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = 16'(ref_mul({8'h0, a}, {8'h0, b}, 8));
        total += 2;
        if (lat !== LAT8) $display("FAIL ign_latency got %0d want %0d", lat, LAT8);
        else passed++;
        if (p8 !== e) $display("FAIL ign_product got %h want %h", p8, e);
        else passed++;
    endtask

    task automatic test_reset_midop();
        logic [15:0] p, e;
        logic [1:0]  s0;
        int          lat;
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'hFF;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (busy8 !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy8);
        else passed++;
        if (done8 !== 1'b0) $display("FAIL rst_mid_done got %b want 0", done8);
        else passed++;
        if (p8 !== 16'h0) $display("FAIL rst_mid_prod got %h want 0", p8);
        else passed++;
        if (st8 !== 2'd0) $display("FAIL rst_mid_state got %0d want 0", st8);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT8 + 2) @(posedge clk);
        #1;
        total++;
        if (st8 !== 2'd0 || done8 !== 1'b0)
            $display("FAIL rst_no_resume got s%0d d%b want s0 d0", st8, done8);
        else passed++;
        run8(8'h9E, 8'h3B, p, lat, s0);
        e = 16'(ref_mul(16'h9E, 16'h3B, 8));
        total += 2;
        if (lat !== LAT8) $display("FAIL rst_after_lat got %0d want %0d", lat, LAT8);
        else passed++;
        if (p !== e) $display("FAIL rst_after_prod got %h want %h", p, e);
        else passed++;
    endtask

    task automatic test_wide();
        logic [31:0] p, e;
        int          lat;
        run16(16'hABCD, 16'h1234, p, lat);
        e = ref_mul(16'hABCD, 16'h1234, 16);
        total += 2;
        if (lat !== LAT16) $display("FAIL w16_latency got %0d want %0d", lat, LAT16);
        else passed++;
        if (p !== e) $display("FAIL w16_product got %h want %h", p, e);
        else passed++;
    endtask

    task automatic test_signed_vectors();
        logic [15:0] p, e;
        logic [1:0]  s0;
        int          lat;
        run8(8'hFD, 8'h05, p, lat, s0);
        e = 16'(ref_mul(16'hFD, 16'h05, 8));
        total += 2;
        if (lat !== LAT8) $display("FAIL sv1_latency got %0d want %0d", lat, LAT8);
        else passed++;
        if (p !== e) $display("FAIL sv1_product got %h want %h", p, e);
        else passed++;
        run8(8'h80, 8'h80, p, lat, s0);
        e = 16'(ref_mul(16'h80, 16'h80, 8));
        total++;
        if (p !== e) $display("FAIL sv2_product got %h want %h", p, e);
        else passed++;
        run8(8'h80, 8'h7F, p, lat, s0);
        e = 16'(ref_mul(16'h80, 16'h7F, 8));
        total++;
        if (p !== e) $display("FAIL sv3_product got %h want %h", p, e);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [15:0] a2, b2;
        logic [15:0] p, e;
        logic [31:0] p2, e2;
        logic [1:0]  s0;
        int          lat;
        for (int k = 0; k < 24; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run8(a, b, p, lat, s0);
            e = 16'(ref_mul({8'h0, a}, {8'h0, b}, 8));
            total++;
            if (p !== e || lat !== LAT8)
                $display("FAIL rnd8 %h*%h got %h lat %0d want %h lat %0d",
                         a, b, p, lat, e, LAT8);
            else passed++;
        end
        for (int k = 0; k < 8; k++) begin
            a2 = 16'($urandom);
            b2 = 16'($urandom);
            run16(a2, b2, p2, lat);
            e2 = ref_mul(a2, b2, 16);
            total++;
            if (p2 !== e2 || lat !== LAT16)
                $display("FAIL rnd16 %h*%h got %h lat %0d want %h lat %0d",
                         a2, b2, p2, lat, e2, LAT16);
            else passed++;
        end
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst_n   = 1'b0;
        start8  = 1'b0;
        start16 = 1'b0;
        a8      = '0;
        b8      = '0;
        a16     = '0;
        b16     = '0;
        test_reset();
        test_ff();
        test_back_to_back();
        test_ignore_start();
        test_reset_midop();
        test_wide();
        test_signed_vectors();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
